mux_scan_ctrl: RTL and testbench
================================

Name: mux_scan_ctrl

Overview:
- Sequential controller that sits directly upstream and downstream of the 4x1 mux (mux_4x1).
- Drives the mux's 2-bit select, scanning the enabled channels in ascending order.
- Waits a programmable dwell time on each channel, then captures the mux output Y into a per-channel result register.
- Uses a start/busy/done handshake, so a scan of the 4 mux inputs becomes a single registered 4-bit snapshot.

Parameters:
- DWELL, 2, number of clock cycles the select is held per channel before Y is captured; legal range 1..15.
- CNT_W, 4, width of the dwell counter; must hold DWELL.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a scan; sampled only in IDLE.
- mask  input  4  channel enable, bit i = scan channel i; latched when start is accepted.
- mux_y  input  1  mux output Y, driven by the mux selected by sel.
- sel  output  2  mux select S[1:0].
- busy  output  1  high while a scan is in progress.
- done  output  1  single-cycle pulse when a scan completes.
- sample  output  4  captured Y per channel; bit i = Y seen with sel=i; masked channels read 0.
- valid  output  1  sample holds a complete result.

Behaviour:
- Reset (asynchronous, immediate, also mid-scan): state=IDLE, sel=0, busy=0, done=0, sample=0, valid=0, dwell counter=0, latched mask=0.
- States: IDLE, DWELL, DONE.
- IDLE, start=1, mask!=0, at edge E0:
  - latch mask, clear sample and valid, set busy=1;
  - set sel to the lowest set bit of mask, load the dwell counter, go to DWELL.
- IDLE, start=1, mask==0: go to DONE directly; sample=0, valid=1 and done=1 in the following cycle; sel unchanged.
- DWELL: the counter decrements each cycle. On the edge where the channel has been held DWELL cycles:
  - sample[sel] <= mux_y;
  - if a higher set bit remains in the latched mask, sel moves to it on the same edge and the counter reloads;
  - otherwise go to DONE.
- Timing: for N enabled channels, capture k (k=1..N) occurs at edge E0+k*DWELL. The last capture edge sets busy=0, done=1 and valid=1 for the next cycle.
- DONE: lasts exactly one cycle, then returns to IDLE; done is cleared. sample and valid hold until the next accepted start or reset.
- A start asserted in IDLE on the same cycle that done is high is not accepted, because the FSM is in DONE. It is accepted on the next cycle.
- start while busy is ignored, and mask changes during a scan are ignored.
- sel holds its last value in IDLE. sel never points at a masked channel while busy=1.
- Non-contiguous masks (e.g. 4'b1010) skip disabled channels with no idle cycles between channels.
- Latency from start acceptance to done = N*DWELL + 1 cycles.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, DWELL, DONE);
  - constants NUM_CH=4 and SEL_W=2;
  - DWELL_MAX=15.
- One sub-module, mux_scan_next_ch: combinational "next set bit strictly above index" finder over a 4-bit mask, outputting next_idx[1:0] and found. It is also used with index -1 to find the first channel.
- Everything else stays in mux_scan_ctrl.

Test Plan:
- In all scenarios the bench models the mux as mux_y = A[sel].
- Full scan: DWELL=2, A=4'b1101, mask=4'b1111, start pulse. Required: sel goes 0,1,2,3 with each value held 2 cycles; done 9 cycles after start edge; sample=4'b1101; valid=1.
- Sparse mask: A=4'b0110, mask=4'b1010. Required: sel goes 1 then 3; sample=4'b0010; done 5 cycles after start.
- Empty mask: mask=0, start. Required: busy never asserts; done=1 the next cycle; sample=0; valid=1.
- Start ignored while busy: start held high through a full scan with mask=4'b0011. Required: exactly one done pulse, followed by a new scan accepted one cycle after done.
- Reset mid-scan: assert rst during channel 2 of a 4'b1111 scan. Required: busy, done, valid, sample and sel go to 0 immediately without waiting for a clock edge. A later start with A=4'b1011 and mask=4'b1111 returns sample=4'b1011.
- Data changes between scans: scan A=4'b1101, then scan A=4'b0010 with mask=4'b1111. Required: the second result is 4'b0010, with no stale bits left from the first scan.

Source files
------------

// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and constants for the 4-channel mux scan controller.
package mux_scan_ctrl_pkg;

  localparam int NUM_CH    = 4;
  localparam int SEL_W     = 2;
  localparam int DWELL_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage : mux_scan_ctrl_pkg

// File: rtl/mux_scan_ctrl_if.sv
// Handshake and mux-facing signals of the scan controller.
// The master side requests scans and supplies Y; the slave side is the controller.
interface mux_scan_ctrl_if;
  import mux_scan_ctrl_pkg::*;

  logic              start;
  logic [NUM_CH-1:0] mask;
  logic              mux_y;
  logic [SEL_W-1:0]  sel;
  logic              busy;
  logic              done;
  logic [NUM_CH-1:0] sample;
  logic              valid;

  modport master (
    output start, mask, mux_y,
    input  sel, busy, done, sample, valid
  );

  modport slave (
    input  start, mask, mux_y,
    output sel, busy, done, sample, valid
  );

endinterface : mux_scan_ctrl_if

// File: rtl/mux_scan_next_ch.sv
// Finds the lowest set mask bit strictly above i_idx; i_idx = -1 yields the first set bit.
module mux_scan_next_ch
  import mux_scan_ctrl_pkg::*;
(
  input  logic [NUM_CH-1:0]   i_mask,
  input  logic signed [SEL_W:0] i_idx,
  output logic [SEL_W-1:0]    o_next_idx,
  output logic                o_found
);

  // Scanning downward lets the lowest qualifying bit win the last assignment.
  always_comb begin
    o_next_idx = '0;
    o_found    = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_mask[i] && (i > int'(i_idx))) begin
        o_next_idx = SEL_W'(i);
        o_found    = 1'b1;
      end
    end
  end

endmodule : mux_scan_next_ch

// File: rtl/mux_scan_ctrl.sv
// Scans the enabled inputs of a 4x1 mux in ascending order, dwelling on each channel
// before capturing Y, and presents the result as one registered 4-bit snapshot.
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int DWELL = 2,
  parameter int CNT_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  mux_scan_ctrl_if.slave bus
);

  // Out-of-range dwell values are clamped to the legal 1..DWELL_MAX window.
  localparam int DWELL_C = (DWELL > DWELL_MAX) ? DWELL_MAX : ((DWELL < 1) ? 1 : DWELL);
  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_C);

  state_t            r_state, w_state_nxt;
  logic [SEL_W-1:0]  r_sel, w_sel_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [NUM_CH-1:0] r_mask, w_mask_nxt;
  logic [NUM_CH-1:0] r_sample, w_sample_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;

  logic [SEL_W-1:0]  w_first_idx, w_next_idx;
  logic              w_first_found, w_next_found;

  mux_scan_next_ch u_first_ch (
    .i_mask     (bus.mask),
    .i_idx      ('1),
    .o_next_idx (w_first_idx),
    .o_found    (w_first_found)
  );

  mux_scan_next_ch u_next_ch (
    .i_mask     (r_mask),
    .i_idx      ({1'b0, r_sel}),
    .o_next_idx (w_next_idx),
    .o_found    (w_next_found)
  );

  // NOTE: every signal gets a hold/default value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_cnt_nxt    = r_cnt;
    w_mask_nxt   = r_mask;
    w_sample_nxt = r_sample;
    w_valid_nxt  = r_valid;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_sample_nxt = '0;
          if (w_first_found) begin
            w_mask_nxt  = bus.mask;
            w_valid_nxt = 1'b0;
            w_busy_nxt  = 1'b1;
            w_sel_nxt   = w_first_idx;
            w_cnt_nxt   = DWELL_LD;
            w_state_nxt = ST_DWELL;
          end else begin
            // Empty mask: report an all-zero result immediately, select untouched.
            w_mask_nxt  = '0;
            w_valid_nxt = 1'b1;
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_DONE;
          end
        end
      end

      ST_DWELL: begin
        if (r_cnt == CNT_W'(1)) begin
          w_sample_nxt[r_sel] = bus.mux_y;
          if (w_next_found) begin
            w_sel_nxt = w_next_idx;
            w_cnt_nxt = DWELL_LD;
          end else begin
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_valid_nxt = 1'b1;
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      ST_DONE: w_state_nxt = ST_IDLE;

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_sel    <= '0;
      r_cnt    <= '0;
      r_mask   <= '0;
      r_sample <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_cnt    <= w_cnt_nxt;
      r_mask   <= w_mask_nxt;
      r_sample <= w_sample_nxt;
      r_valid  <= w_valid_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign bus.sel    = r_sel;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.sample = r_sample;
  assign bus.valid  = r_valid;

endmodule : mux_scan_ctrl

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: the mux is modelled as mux_y = a[sel] and every
// expected value is a hand-computed constant for DWELL = 2.
module tb_mux_scan_ctrl;

  localparam int TB_DWELL = 2;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  int         n_vec;
  int         n_err;

  mux_scan_ctrl_if bus ();

  mux_scan_ctrl #(.DWELL(TB_DWELL), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.mux_y = a[bus.sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycle 0 is the cycle start is driven; capture edges follow, done is seen in cycle n*DWELL+1.
  // sel_seq packs the expected select per scanned channel, first channel in bits [1:0].
  task automatic run_scan(input string tag, input logic [3:0] a_in, input logic [3:0] m,
                          input int n_ch, input logic [7:0] sel_seq, input logic [3:0] exp_sample);
    logic [1:0] exp_sel;
    a         = a_in;
    bus.mask  = m;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c <= n_ch * TB_DWELL; c++) begin
      exp_sel = sel_seq[2*((c-1)/TB_DWELL) +: 2];
      check({tag, ".sel"}, 32'(bus.sel), 32'(exp_sel));
      check({tag, ".busy"}, 32'(bus.busy), 32'd1);
      check({tag, ".done_lo"}, 32'(bus.done), 32'd0);
      @(negedge clk);
    end
    check({tag, ".done"}, 32'(bus.done), 32'd1);
    check({tag, ".busy_end"}, 32'(bus.busy), 32'd0);
    check({tag, ".sample"}, 32'(bus.sample), 32'(exp_sample));
    check({tag, ".valid"}, 32'(bus.valid), 32'd1);
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, ".sample_hold"}, 32'(bus.sample), 32'(exp_sample));
    check({tag, ".valid_hold"}, 32'(bus.valid), 32'd1);
  endtask

  initial begin
    int done_cnt;
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    a         = 4'b0000;
    bus.start = 1'b0;
    bus.mask  = 4'b0000;

    // Reset state
    #2;
    check("rst.sel", 32'(bus.sel), 32'd0);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    check("rst.sample", 32'(bus.sample), 32'd0);
    check("rst.valid", 32'(bus.valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Full scan: sel 0,1,2,3
    run_scan("full", 4'b1101, 4'b1111, 4, 8'b11_10_01_00, 4'b1101);

    // Sparse mask skips channels 0 and 2
    run_scan("sparse", 4'b0110, 4'b1010, 2, 8'b00_00_11_01, 4'b0010);

    // Empty mask: no busy, done next cycle, sel held at 3
    bus.mask  = 4'b0000;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("empty.busy", 32'(bus.busy), 32'd0);
    check("empty.done", 32'(bus.done), 32'd1);
    check("empty.sample", 32'(bus.sample), 32'd0);
    check("empty.valid", 32'(bus.valid), 32'd1);
    check("empty.sel", 32'(bus.sel), 32'd3);
    @(negedge clk);
    check("empty.done_pulse", 32'(bus.done), 32'd0);
    check("empty.busy2", 32'(bus.busy), 32'd0);

    // Start held high through a scan; mask changes mid-scan are ignored
    a         = 4'b0110;
    bus.mask  = 4'b0011;
    bus.start = 1'b1;
    done_cnt  = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 2) bus.mask = 4'b1100;
      if (c == 4) bus.mask = 4'b0011;
      if (bus.done) done_cnt++;
      if (c <= 4) check("hold.busy", 32'(bus.busy), 32'd1);
    end
    check("hold.done_cnt", 32'(done_cnt), 32'd1);
    check("hold.sample", 32'(bus.sample), 32'b0010);
    check("hold.idle_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    check("hold.reaccept_busy", 32'(bus.busy), 32'd1);
    check("hold.reaccept_sel", 32'(bus.sel), 32'd0);
    check("hold.reaccept_valid", 32'(bus.valid), 32'd0);
    repeat (4) @(negedge clk);
    check("hold.second_done", 32'(bus.done), 32'd1);
    check("hold.second_sample", 32'(bus.sample), 32'b0010);
    @(negedge clk);

    // Reset in the middle of channel 2 must clear outputs without a clock edge
    a         = 4'b1111;
    bus.mask  = 4'b1111;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid.sel_before", 32'(bus.sel), 32'd2);
    check("mid.sample_before", 32'(bus.sample), 32'b0011);
    #2 rst = 1'b1;
    #1;
    check("mid.busy", 32'(bus.busy), 32'd0);
    check("mid.done", 32'(bus.done), 32'd0);
    check("mid.valid", 32'(bus.valid), 32'd0);
    check("mid.sample", 32'(bus.sample), 32'd0);
    check("mid.sel", 32'(bus.sel), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_scan("post_rst", 4'b1011, 4'b1111, 4, 8'b11_10_01_00, 4'b1011);

    // Back-to-back scans with different data leave no stale bits
    run_scan("data1", 4'b1101, 4'b1111, 4, 8'b11_10_01_00, 4'b1101);
    run_scan("data2", 4'b0010, 4'b1111, 4, 8'b11_10_01_00, 4'b0010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule : tb_mux_scan_ctrl
